i3c_xfer_arbiter: RTL

I3C_XFER_ARBITER -- requirements
Module: i3c_xfer_arbiter

---
 rtl/i3c_xfer_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/i3c_xfer_arbiter.sv
// i3c_xfer_arbiter: round-robin arbiter sharing one I3C controller among NUM_REQ requesters.
// Defining I3C_ARB_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module i3c_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]              req_is_read_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                            rsp_error_o,
    output logic                            ctl_start_o,
    output logic [ADDR_WIDTH-1:0]           ctl_addr_o,
    output logic                            ctl_is_read_o,
    output logic [DATA_WIDTH-1:0]           ctl_wdata_o,
    input  logic [DATA_WIDTH-1:0]           ctl_rdata_i,
    input  logic                            ctl_done_i,
    input  logic                            ctl_error_i,
    output logic                            busy_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o
);
    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("i3c_xfer_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_q, grant_q, sel_id;
    logic                  sel_found;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  err_q;
    logic                  ctl_fin, accept, rsp_hs, tmo;

    // Scan from the farthest offset down so the nearest valid requester after last_q wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(last_q) + 1 + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_id    = GW'((int'(last_q) + 1 + k) % NUM_REQ);
            end
        end
    end

    assign ctl_fin = ctl_done_i | ctl_error_i;
    assign accept  = (state_q == IDLE) && sel_found;
    assign rsp_hs  = (state_q == RESP) && rsp_ready_i[grant_q];

`ifdef I3C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            tmo_cnt_q <= '0;
        else if (state_q == LAUNCH)
            tmo_cnt_q <= '0;
        else if (state_q == WAIT)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    assign tmo = (state_q == WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Ready is gated by rst_ni so it is low for the whole reset interval.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d             = LAUNCH;
                    req_ready_o[sel_id] = rst_ni;
                end
            end
            LAUNCH:  state_d = WAIT;
            WAIT:    state_d = (ctl_fin || tmo) ? RESP : WAIT;
            RESP:    state_d = rsp_ready_i[grant_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= sel_id;
                addr_q  <= req_addr_i[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
                rd_q    <= req_is_read_i[sel_id];
                wdata_q <= req_wdata_i[sel_id*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == WAIT && ctl_fin) begin
                err_q   <= ctl_error_i;
                rdata_q <= rd_q ? ctl_rdata_i : '0;
            end else if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (rsp_hs) begin
                last_q  <= grant_q;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    assign busy_o        = state_q != IDLE;
    assign ctl_start_o   = state_q == LAUNCH;
    assign ctl_addr_o    = busy_o ? addr_q : '0;
    assign ctl_is_read_o = busy_o & rd_q;
    assign ctl_wdata_o   = busy_o ? wdata_q : '0;
    assign rsp_valid_o   = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_error_o   = err_q;
    assign grant_id_o    = grant_q;

endmodule
